// File: rtl/sram_pkg.sv
// Shared types, defaults and elaboration helpers for the burst-capable
// asynchronous SRAM controller.
package sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_e;

    localparam int DEF_ADDR_W  = 18;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_RD_WAIT = 2;
    localparam int DEF_WR_WAIT = 2;
    localparam int DEF_BURST_W = 3;

    function automatic int nbyte(input int data_w);
        return data_w / 8;
    endfunction

    function automatic bit data_w_ok(input int data_w);
        return (data_w > 0) && (data_w % 8 == 0);
    endfunction

    // The wait counter only ever holds (wait - 1), so size it for the larger
    // of the two wait settings minus one.
    function automatic int wait_cnt_w(input int rd_wait, input int wr_wait);
        int m;
        m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter with a terminal flag; times both the read strobe
// window and the write-enable pulse.
module sram_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl_burst.sv
// Asynchronous-SRAM controller with programmable wait states, byte enables
// and fixed-length bursts with wrapping address auto-increment.
module sram_ctrl_burst
    import sram_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RD_WAIT = DEF_RD_WAIT,
    parameter int WR_WAIT = DEF_WR_WAIT,
    parameter int BURST_W = DEF_BURST_W,
    localparam int NBYTE  = nbyte(DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem,
    input  logic               rw,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DATA_W-1:0]  data_f2s,
    input  logic [NBYTE-1:0]   be_f2s,
    output logic               wr_ack,
    output logic               ready,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  data_s2f_r,
    output logic [DATA_W-1:0]  data_s2f_ur,
    output logic [ADDR_W-1:0]  ad,
    inout  wire  [DATA_W-1:0]  dio,
    output logic               ce_n,
    output logic               we_n,
    output logic               oe_n,
    output logic [NBYTE-1:0]   be_n
);

    localparam int CNT_W = wait_cnt_w(RD_WAIT, WR_WAIT);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    if (!data_w_ok(DATA_W) || RD_WAIT < 1 || WR_WAIT < 1) begin : g_bad_param
        $error("sram_ctrl_burst: DATA_W must be a multiple of 8 and waits >= 1");
    end

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    ad_q, ad_d;
    logic [BURST_W-1:0]   beats_q, beats_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [NBYTE-1:0]     be_q, be_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 ce_n_q, ce_n_d;
    logic                 we_n_q, we_n_d;
    logic                 oe_n_q, oe_n_d;
    logic [NBYTE-1:0]     be_n_q, be_n_d;
    logic                 dio_oe_q, dio_oe_d;

    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_load_val;
    logic                 cnt_done;
    logic                 capture;

    sram_wait_cnt #(
        .W(CNT_W)
    ) u_wait (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .done_o    (cnt_done)
    );

    always_comb begin : p_next
        state_d      = state_q;
        ad_d         = ad_q;
        beats_d      = beats_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        wr_ack       = 1'b0;
        capture      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem) begin
                    ad_d    = addr;
                    beats_d = burst_len;
                    if (rw) begin
                        state_d      = ST_RD;
                        cnt_load     = 1'b1;
                        cnt_load_val = RD_LOAD;
                    end else begin
                        // Beat-0 write data is taken on the acceptance edge.
                        wr_ack  = 1'b1;
                        state_d = ST_WR_SETUP;
                    end
                end
            end
            ST_RD: begin
                if (cnt_done) begin
                    capture = 1'b1;
                    if (beats_q != '0) begin
                        beats_d      = beats_q - BURST_W'(1);
                        ad_d         = ad_q + ADDR_W'(1);
                        cnt_load     = 1'b1;
                        cnt_load_val = RD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WR_SETUP: begin
                state_d      = ST_WR_PULSE;
                cnt_load     = 1'b1;
                cnt_load_val = WR_LOAD;
            end
            ST_WR_PULSE: begin
                if (cnt_done) begin
                    state_d = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                if (beats_q != '0) begin
                    wr_ack  = 1'b1;
                    beats_d = beats_q - BURST_W'(1);
                    ad_d    = ad_q + ADDR_W'(1);
                    state_d = ST_WR_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so the pins change cleanly
    // on the same edge as the state register.
    always_comb begin : p_regs_next
        wdata_d    = wr_ack ? data_f2s : wdata_q;
        be_d       = wr_ack ? be_f2s : be_q;
        rd_valid_d = capture;
        rdata_d    = capture ? dio : rdata_q;
        ce_n_d     = (state_d == ST_IDLE);
        oe_n_d     = (state_d != ST_RD);
        we_n_d     = (state_d != ST_WR_PULSE);
        dio_oe_d   = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                     (state_d == ST_WR_HOLD);
    end

    for (genvar gi = 0; gi < NBYTE; gi++) begin : g_lane
        assign be_n_d[gi] = (state_d == ST_RD) ? 1'b0 :
                            (dio_oe_d ? ~be_d[gi] : 1'b1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ad_q       <= '0;
            beats_q    <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            be_n_q     <= '1;
            dio_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ad_q       <= ad_d;
            beats_q    <= beats_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            be_n_q     <= be_n_d;
            dio_oe_q   <= dio_oe_d;
        end
    end

    assign dio         = dio_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign data_s2f_ur = dio_oe_q ? '0 : dio;
    assign data_s2f_r  = rdata_q;
    assign rd_valid    = rd_valid_q;
    assign ready       = (state_q == ST_IDLE);
    assign ad          = ad_q;
    assign ce_n        = ce_n_q;
    assign we_n        = we_n_q;
    assign oe_n        = oe_n_q;
    assign be_n        = be_n_q;

endmodule

// File: tb/tb_sram_ctrl_burst.sv
// Directed bench: three controller instances (default, 1/1 and 4/3 wait
// states), each with its own behavioural SRAM on the pins.
module tb_sram_ctrl_burst;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int NB = 2;
    localparam int BW = 3;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          mem;
    logic          rw;
    logic [AW-1:0] addr;
    logic [BW-1:0] burst_len;
    logic [DW-1:0] data_f2s;
    logic [NB-1:0] be_f2s;
    int            sel;
    logic          tb_en;
    logic [DW-1:0] tb_pat;

    logic [NI-1:0] wr_ack_w, ready_w, rd_valid_w, ce_n_w, we_n_w, oe_n_w;
    logic [DW-1:0] rdata_w [NI];
    logic [DW-1:0] ur_w    [NI];
    logic [AW-1:0] ad_w    [NI];
    logic [NB-1:0] be_n_w  [NI];

    genvar gi;
    for (gi = 0; gi < NI; gi++) begin : g_dut
        localparam int RW_P = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
        localparam int WW_P = (gi == 0) ? 2 : ((gi == 1) ? 1 : 3);
        wire  [DW-1:0] dio;
        logic [DW-1:0] sram [0:(1<<AW)-1];
        logic [DW-1:0] sram_rd;
        logic          mem_g;

        assign mem_g   = mem && (sel == gi);
        assign sram_rd = sram[ad_w[gi]];
        assign dio = (!ce_n_w[gi] && !oe_n_w[gi] && we_n_w[gi]) ? sram_rd : {DW{1'bz}};
        assign dio = tb_en ? tb_pat : {DW{1'bz}};

        always @(posedge we_n_w[gi]) begin
            if (!ce_n_w[gi]) begin
                for (int b = 0; b < NB; b++) begin
                    if (!be_n_w[gi][b]) sram[ad_w[gi]][b*8 +: 8] = dio[b*8 +: 8];
                end
            end
        end

        sram_ctrl_burst #(
            .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RW_P), .WR_WAIT(WW_P), .BURST_W(BW)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .mem        (mem_g),
            .rw         (rw),
            .addr       (addr),
            .burst_len  (burst_len),
            .data_f2s   (data_f2s),
            .be_f2s     (be_f2s),
            .wr_ack     (wr_ack_w[gi]),
            .ready      (ready_w[gi]),
            .rd_valid   (rd_valid_w[gi]),
            .data_s2f_r (rdata_w[gi]),
            .data_s2f_ur(ur_w[gi]),
            .ad         (ad_w[gi]),
            .dio        (dio),
            .ce_n       (ce_n_w[gi]),
            .we_n       (we_n_w[gi]),
            .oe_n       (oe_n_w[gi]),
            .be_n       (be_n_w[gi])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-transaction results
    int            busy, we_low, wa_cnt, lat, nrd, nad;
    bit            first_wa;
    logic [AW-1:0] b_ad  [8];
    logic [NB-1:0] b_ben [8];
    logic [DW-1:0] rd_dat[8];
    logic [DW-1:0] wdat  [8];
    logic [NB-1:0] wbe   [8];

    task automatic do_write(input int s, input logic [AW-1:0] a, input int n);
        int   beat;
        logic wa;
        bit   done;
        sel = s; mem = 1'b1; rw = 1'b0; addr = a; burst_len = BW'(n - 1);
        data_f2s = wdat[0]; be_f2s = wbe[0];
        busy = 0; we_low = 0; wa_cnt = 0; beat = 0; done = 0;
        #1;
        first_wa = wr_ack_w[s];
        for (int c = 0; c < 300 && !done; c++) begin
            wa = wr_ack_w[s];
            tick();
            if (c == 0) mem = 1'b0;
            if (wa && beat < 8) begin
                b_ad[beat]  = ad_w[s];
                b_ben[beat] = be_n_w[s];
                wa_cnt++;
                beat++;
                if (beat < 8) begin
                    data_f2s = wdat[beat];
                    be_f2s   = wbe[beat];
                end
            end
            if (ready_w[s]) done = 1;
            else begin
                busy++;
                if (!we_n_w[s]) we_low++;
            end
        end
        if (!done) check_eq("wr_timeout", 32'd0, 32'd1);
        $display("[TB] dut%0d write addr=%05h beats=%0d acks=%0d busy=%0d we_low=%0d",
                 s, a, n, wa_cnt, busy, we_low);
    endtask

    task automatic do_read(input int s, input logic [AW-1:0] a, input int n);
        bit done;
        sel = s; mem = 1'b1; rw = 1'b1; addr = a; burst_len = BW'(n - 1);
        busy = 0; lat = 0; nrd = 0; nad = 0; done = 0;
        #1;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (c == 0) mem = 1'b0;
            if (!oe_n_w[s] && nad < 8 && (nad == 0 || ad_w[s] != b_ad[nad-1])) begin
                b_ad[nad] = ad_w[s];
                nad++;
            end
            if (rd_valid_w[s] && nrd < 8) begin
                if (nrd == 0) lat = c + 1;
                rd_dat[nrd] = rdata_w[s];
                nrd++;
            end
            if (ready_w[s]) done = 1;
            else busy++;
        end
        if (!done) check_eq("rd_timeout", 32'd0, 32'd1);
        $display("[TB] dut%0d read  addr=%05h beats=%0d got=%0d latency=%0d first=%04h",
                 s, a, n, nrd, lat, rd_dat[0]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] exp_ad [4];
    int rdv, wcnt, ccnt;

    initial begin
        reset = 1'b0; mem = 1'b0; rw = 1'b0; addr = '0; burst_len = '0;
        data_f2s = '0; be_f2s = '0; sel = 0; tb_en = 1'b1; tb_pat = 16'hA55A;
        exp_ad[0] = 18'h3FFFE; exp_ad[1] = 18'h3FFFF; exp_ad[2] = 18'h00000; exp_ad[3] = 18'h00001;

        // Reset state
        rdv = 0;
        repeat (3) begin tick(); rdv += int'(rd_valid_w[0]); end
        check_eq("rst_ready", ready_w[0], 1);
        check_eq("rst_ce_n", ce_n_w[0], 1);
        check_eq("rst_we_n", we_n_w[0], 1);
        check_eq("rst_oe_n", oe_n_w[0], 1);
        check_eq("rst_be_n", be_n_w[0], 2'b11);
        check_eq("rst_ad", ad_w[0], 0);
        check_eq("rst_rdata", rdata_w[0], 0);
        check_eq("rst_dio_hiz", ur_w[0], 16'hA55A);
        @(negedge clk) reset = 1'b1;
        repeat (5) begin tick(); rdv += int'(rd_valid_w[0]) + int'(rd_valid_w[1]) + int'(rd_valid_w[2]); end
        check_eq("idle_rd_valid", rdv, 0);
        check_eq("idle_ready", ready_w, 3'b111);
        check_eq("idle_ce_n", ce_n_w, 3'b111);
        tb_en = 1'b0;

        // Single write then read
        wdat[0] = 16'h00F0; wbe[0] = 2'b11;
        do_write(0, 18'h000F0, 1);
        check_eq("w1_ack_accept", first_wa, 1);
        check_eq("w1_acks", wa_cnt, 1);
        check_eq("w1_we_low", we_low, 2);
        check_eq("w1_busy", busy, 4);
        check_eq("w1_ad", b_ad[0], 18'h000F0);
        tb_en = 1'b1; tb_pat = 16'h5AA5; #1;
        check_eq("w1_dio_released", ur_w[0], 16'h5AA5);
        tb_en = 1'b0;
        do_read(0, 18'h000F0, 1);
        check_eq("r1_latency", lat, 3);
        check_eq("r1_count", nrd, 1);
        check_eq("r1_data", rd_dat[0], 16'h00F0);
        check_eq("r1_busy", busy, 2);

        // Four-beat burst across the address wrap
        wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;
        for (int i = 0; i < 4; i++) wbe[i] = 2'b11;
        do_write(0, 18'h3FFFE, 4);
        check_eq("wb_acks", wa_cnt, 4);
        check_eq("wb_busy", busy, 16);
        for (int i = 0; i < 4; i++) check_eq($sformatf("wb_ad%0d", i), b_ad[i], exp_ad[i]);
        do_read(0, 18'h3FFFE, 4);
        check_eq("rb_count", nrd, 4);
        check_eq("rb_nad", nad, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rb_ad%0d", i), b_ad[i], exp_ad[i]);
            check_eq($sformatf("rb_data%0d", i), rd_dat[i], wdat[i]);
        end

        // Byte lanes
        wdat[0] = 16'hABCD; wbe[0] = 2'b11;
        do_write(0, 18'h00100, 1);
        wdat[0] = 16'h12FF; wbe[0] = 2'b01;
        do_write(0, 18'h00100, 1);
        check_eq("bl_be_n", b_ben[0], 2'b10);
        do_read(0, 18'h00100, 1);
        check_eq("bl_data", rd_dat[0], 16'hABFF);

        // All lanes disabled: full timing, memory untouched
        wdat[0] = 16'hFFFF; wbe[0] = 2'b00;
        do_write(0, 18'h00100, 1);
        check_eq("be0_busy", busy, 4);
        check_eq("be0_we_low", we_low, 2);
        check_eq("be0_be_n", b_ben[0], 2'b11);
        do_read(0, 18'h00100, 1);
        check_eq("be0_data", rd_dat[0], 16'hABFF);

        // Request while busy, then reset mid write pulse
        wdat[0] = 16'hDEAD; wdat[1] = 16'hBEEF;
        sel = 0; mem = 1'b1; rw = 1'b0; addr = 18'h00200; burst_len = 3'd3;
        data_f2s = wdat[0]; be_f2s = 2'b11;
        tick();
        data_f2s = wdat[1]; rw = 1'b1; addr = 18'h00300;
        #1;
        check_eq("busy_ready", ready_w[0], 0);
        check_eq("busy_rd_ack", wr_ack_w[0], 0);
        rw = 1'b0; #1;
        check_eq("busy_wr_ack", wr_ack_w[0], 0);
        tick();
        check_eq("busy_we_pulse", we_n_w[0], 0);
        check_eq("busy_no_read", oe_n_w[0], 1);
        mem = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("arst_we_n", we_n_w[0], 1);
        check_eq("arst_ce_n", ce_n_w[0], 1);
        check_eq("arst_oe_n", oe_n_w[0], 1);
        check_eq("arst_ready", ready_w[0], 1);
        check_eq("arst_be_n", be_n_w[0], 2'b11);
        check_eq("arst_ad", ad_w[0], 0);
        tb_en = 1'b1; tb_pat = 16'h3C3C; #1;
        check_eq("arst_dio_hiz", ur_w[0], 16'h3C3C);
        wcnt = 0; ccnt = 0;
        repeat (3) begin tick(); wcnt += int'(wr_ack_w[0]); ccnt += int'(!ce_n_w[0]); end
        @(negedge clk) reset = 1'b1;
        repeat (6) begin tick(); wcnt += int'(wr_ack_w[0]); ccnt += int'(!ce_n_w[0]); end
        check_eq("arst_no_ack", wcnt, 0);
        check_eq("arst_no_strobe", ccnt, 0);
        check_eq("arst_rdata", rdata_w[0], 0);
        tb_en = 1'b0;

        // Wait-state sweep
        wdat[0] = 16'h5A5A; wbe[0] = 2'b11;
        do_write(1, 18'h00040, 1);
        check_eq("s11_wr_busy", busy, 3);
        check_eq("s11_we_low", we_low, 1);
        do_read(1, 18'h00040, 1);
        check_eq("s11_rd_lat", lat, 2);
        check_eq("s11_rd_data", rd_dat[0], 16'h5A5A);
        wdat[0] = 16'hC3A5;
        do_write(2, 18'h00041, 1);
        check_eq("s43_wr_busy", busy, 5);
        check_eq("s43_we_low", we_low, 3);
        do_read(2, 18'h00041, 1);
        check_eq("s43_rd_lat", lat, 5);
        check_eq("s43_rd_busy", busy, 4);
        check_eq("s43_rd_data", rd_dat[0], 16'hC3A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
